rat_flags_int: RTL

RAT_FLAGS_INT -- requirements
Module: rat_flags_int

---
 rtl/rat_flags_int_if.sv | 31 +++
 rtl/rat_flags_int.sv | 88 ++++++++
 2 files changed

// File: rtl/rat_flags_int_if.sv
// Control-unit side bundle for the flag/interrupt block: commands, ALU results, interrupt request/ack and flag outputs.
interface rat_flags_int_if;
   logic flg_c_set;
   logic flg_c_clr;
   logic flg_c_ld;
   logic flg_z_ld;
   logic flg_ld_sel;
   logic c_in;
   logic z_in;
   logic i_set;
   logic i_clr;
   logic int_req;
   logic int_ack;
   logic c_flag;
   logic z_flag;
   logic i_flag;
   logic int_pending;
   logic int_cu;

   modport master (
      output flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld, flg_ld_sel,
      output c_in, z_in, i_set, i_clr, int_req, int_ack,
      input  c_flag, z_flag, i_flag, int_pending, int_cu
   );

   modport slave (
      input  flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld, flg_ld_sel,
      input  c_in, z_in, i_set, i_clr, int_req, int_ack,
      output c_flag, z_flag, i_flag, int_pending, int_cu
   );
endinterface

// File: rtl/rat_flags_int.sv
// C/Z/I flags with interrupt shadow copies and a rising-edge interrupt latch; latency 1 for all registered outputs.
// RAT_INT_SYNC_EN defined: INT_REQ passes a 2-flop synchronizer before edge detection (pending after 3rd sampling edge).
module rat_flags_int (
   input logic           clk,
   input logic           reset_n,
   rat_flags_int_if.slave bus
);

   logic c_q;
   logic z_q;
   logic shad_c_q;
   logic shad_z_q;
   logic i_q;
   logic pending_q;
   logic prev_q;
   logic req_stage;
   logic req_edge;

`ifdef RAT_INT_SYNC_EN
   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.int_req;
         sync2_q <= sync1_q;
      end
   end

   assign req_stage = sync2_q;
`else
   assign req_stage = bus.int_req;
`endif

   // prev_q starts at 0, so a request already high after reset yields one edge
   assign req_edge = req_stage & ~prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_q       <= 1'b0;
         z_q       <= 1'b0;
         shad_c_q  <= 1'b0;
         shad_z_q  <= 1'b0;
         i_q       <= 1'b0;
         pending_q <= 1'b0;
         prev_q    <= 1'b0;
      end else begin
         prev_q <= req_stage;

         if (bus.flg_c_clr)
            c_q <= 1'b0;
         else if (bus.flg_c_set)
            c_q <= 1'b1;
         else if (bus.flg_c_ld)
            c_q <= bus.flg_ld_sel ? shad_c_q : bus.c_in;

         if (bus.flg_z_ld)
            z_q <= bus.flg_ld_sel ? shad_z_q : bus.z_in;

         // shadows take the flags as they stood before this cycle's update
         if (bus.int_ack) begin
            shad_c_q <= c_q;
            shad_z_q <= z_q;
         end

         if (bus.int_ack || bus.i_clr)
            i_q <= 1'b0;
         else if (bus.i_set)
            i_q <= 1'b1;

         // a fresh edge wins over the ack so a back-to-back request is not dropped
         if (req_edge)
            pending_q <= 1'b1;
         else if (bus.int_ack)
            pending_q <= 1'b0;
      end
   end

   assign bus.c_flag      = c_q;
   assign bus.z_flag      = z_q;
   assign bus.i_flag      = i_q;
   assign bus.int_pending = pending_q;
   assign bus.int_cu      = pending_q & i_q;

endmodule
